// File: rtl/wb_router_pkg.sv
// Shared constants for the Wishbone channel router:
// FSM encoding, default widths, error word and channel map.
package wb_router_pkg;

   localparam int          WB_WIDTH_DEF = 32;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
   localparam int          TMR_W        = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum int {
      CH_PROG    = 0,
      CH_PADS    = 1,
      CH_DEBUG   = 2,
      CH_ENTROPY = 3
   } ch_idx_e;

endpackage

// File: rtl/wb_router_timer.sv
// Per-transfer timeout: loaded with TIMEOUT-1 when a request starts,
// counts down while the target stalls, flags expiry at zero.
module wb_router_timer
   import wb_router_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_o
);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = TMR_W'(TIMEOUT - 1);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - TMR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/wb_router.sv
// Registered Wishbone classic slave routing each transfer to one of
// CHANNELS req/ack targets, with timeout and error reporting.
module wb_router
   import wb_router_pkg::*;
#(
   parameter int                  WB_WIDTH = WB_WIDTH_DEF,
   parameter int                  CHANNELS = 4,
   parameter int                  SEL_BITS = $clog2(CHANNELS),
   parameter int                  TIMEOUT  = 16,
   parameter logic [WB_WIDTH-1:0] ERR_DATA = ERR_DATA_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wbs_stb_i,
   input  logic                         wbs_cyc_i,
   input  logic                         wbs_we_i,
   input  logic [WB_WIDTH-1:0]          wbs_adr_i,
   input  logic [WB_WIDTH-1:0]          wbs_dat_i,
   output logic                         wbs_ack_o,
   output logic                         wbs_err_o,
   output logic [WB_WIDTH-1:0]          wbs_dat_o,
   output logic [CHANNELS-1:0]          ch_req,
   output logic                         ch_we,
   output logic [WB_WIDTH-SEL_BITS-1:0] ch_addr,
   output logic [WB_WIDTH-1:0]          ch_wdata,
   input  logic [CHANNELS-1:0]          ch_ack,
   input  logic [CHANNELS*WB_WIDTH-1:0] ch_rdata,
   output logic [7:0]                   timeout_count,
   output logic [SEL_BITS-1:0]          last_err_ch
);

   localparam int AW = WB_WIDTH - SEL_BITS;

   logic [1:0]          state_q, state_d;
   logic [SEL_BITS-1:0] sel_q, sel_d;
   logic                we_q, we_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [WB_WIDTH-1:0] wdata_q, wdata_d;
   logic [CHANNELS-1:0] req_q, req_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic [WB_WIDTH-1:0] dat_q, dat_d;
   logic [7:0]          tcnt_q, tcnt_d;
   logic [SEL_BITS-1:0] lerr_q, lerr_d;

   logic                t_load, t_en, t_clr, t_exp;
   logic [WB_WIDTH-1:0] rdata_sel;
   logic                ack_sel;

   assign rdata_sel = ch_rdata[int'(sel_q)*WB_WIDTH +: WB_WIDTH];
   assign ack_sel   = ch_ack[sel_q];

   wb_router_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (t_load),
      .en_i     (t_en),
      .clr_i    (t_clr),
      .expire_o (t_exp)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      req_d   = req_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_d   = dat_q;
      tcnt_d  = tcnt_q;
      lerr_d  = lerr_q;
      t_load  = 1'b0;
      t_en    = 1'b0;
      t_clr   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (wbs_stb_i && wbs_cyc_i) begin
               sel_d        = wbs_adr_i[WB_WIDTH-1 -: SEL_BITS];
               we_d         = wbs_we_i;
               addr_d       = wbs_adr_i[AW-1:0];
               wdata_d      = wbs_dat_i;
               req_d        = '0;
               req_d[sel_d] = 1'b1;
               t_load       = 1'b1;
               state_d      = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!wbs_cyc_i || !wbs_stb_i) begin
               req_d   = '0;
               t_clr   = 1'b1;
               state_d = ST_IDLE;
            end else if (ack_sel) begin
               // completion beats a coincident timeout
               req_d   = '0;
               dat_d   = we_q ? '0 : rdata_sel;
               ack_d   = 1'b1;
               t_clr   = 1'b1;
               state_d = ST_RESP;
            end else if (t_exp) begin
               req_d   = '0;
               dat_d   = ERR_DATA;
               err_d   = 1'b1;
               lerr_d  = sel_q;
               t_clr   = 1'b1;
               state_d = ST_RESP;
               if (tcnt_q != 8'hFF) begin
                  tcnt_d = tcnt_q + 8'd1;
               end
            end else begin
               t_en = 1'b1;
            end
         end
         ST_RESP: begin
            dat_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            req_d   = '0;
            dat_d   = '0;
            t_clr   = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         req_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         tcnt_q  <= '0;
         lerr_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
         tcnt_q  <= tcnt_d;
         lerr_q  <= lerr_d;
      end
   end

   assign wbs_ack_o     = ack_q;
   assign wbs_err_o     = err_q;
   assign wbs_dat_o     = dat_q;
   assign ch_req        = req_q;
   assign ch_we         = we_q;
   assign ch_addr       = addr_q;
   assign ch_wdata      = wdata_q;
   assign timeout_count = tcnt_q;
   assign last_err_ch   = lerr_q;

endmodule

// File: tb/tb_wb_router.sv
// Scenario bench for wb_router: directed cases plus randomized
// transfers checked against a transaction-level expectation.
module tb_wb_router;
   import wb_router_pkg::*;

   localparam int          W    = 32;
   localparam int          N    = 4;
   localparam int          SB   = 2;
   localparam int          TO   = 16;
   localparam int          AW   = W - SB;
   localparam logic [W-1:0] ERRV = 32'hDEAD_BEEF;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [W-1:0]   wbs_adr_i, wbs_dat_i;
   logic           wbs_ack_o, wbs_err_o;
   logic [W-1:0]   wbs_dat_o;
   logic [N-1:0]   ch_req;
   logic           ch_we;
   logic [AW-1:0]  ch_addr;
   logic [W-1:0]   ch_wdata;
   logic [N-1:0]   ch_ack;
   logic [N*W-1:0] ch_rdata;
   logic [7:0]     timeout_count;
   logic [SB-1:0]  last_err_ch;
   logic [W-1:0]   rd [N];

   for (genvar g = 0; g < N; g++) begin : g_rd
      assign ch_rdata[g*W +: W] = rd[g];
   end

   always #5 clk = ~clk;

   wb_router #(
      .WB_WIDTH (W),
      .CHANNELS (N),
      .SEL_BITS (SB),
      .TIMEOUT  (TO),
      .ERR_DATA (ERRV)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wbs_stb_i     (wbs_stb_i),
      .wbs_cyc_i     (wbs_cyc_i),
      .wbs_we_i      (wbs_we_i),
      .wbs_adr_i     (wbs_adr_i),
      .wbs_dat_i     (wbs_dat_i),
      .wbs_ack_o     (wbs_ack_o),
      .wbs_err_o     (wbs_err_o),
      .wbs_dat_o     (wbs_dat_o),
      .ch_req        (ch_req),
      .ch_we         (ch_we),
      .ch_addr       (ch_addr),
      .ch_wdata      (ch_wdata),
      .ch_ack        (ch_ack),
      .ch_rdata      (ch_rdata),
      .timeout_count (timeout_count),
      .last_err_ch   (last_err_ch)
   );

   int nvec = 0;
   int nerr = 0;
   int cyc_n = 0;
   int exp_tcnt = 0;
   int exp_last = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   // Drives one transfer; the target acks once req has been up dly+1 cycles.
   task automatic xfer(
      input  int            c,
      input  bit            we,
      input  logic [AW-1:0] lo,
      input  logic [W-1:0]  wd,
      input  int            dly,
      input  bit            noise,
      output bit            got_ack,
      output bit            got_err,
      output logic [W-1:0]  got_dat,
      output int            lat,
      output int            nreq,
      output int            bad,
      output int            first_req,
      output int            resp_cyc
   );
      logic [N-1:0] oh;
      oh = '0;
      oh[c] = 1'b1;
      got_ack = 0; got_err = 0; got_dat = '0;
      lat = 0; nreq = 0; bad = 0; first_req = -1; resp_cyc = -1;
      wbs_adr_i = {SB'(c), lo};
      wbs_we_i  = we;
      wbs_dat_i = wd;
      wbs_stb_i = 1'b1;
      wbs_cyc_i = 1'b1;
      ch_ack    = '0;
      for (int k = 1; k <= TO + 8; k++) begin
         tick();
         if (wbs_ack_o && wbs_err_o) bad++;
         if (wbs_ack_o || wbs_err_o) begin
            got_ack  = wbs_ack_o;
            got_err  = wbs_err_o;
            got_dat  = wbs_dat_o;
            lat      = k;
            resp_cyc = cyc_n;
            if (ch_req !== '0) bad++;
            break;
         end
         if (ch_req !== oh) begin
            bad++;
         end else begin
            nreq++;
            if (first_req < 0) first_req = cyc_n;
         end
         if (ch_we !== we || ch_addr !== lo || ch_wdata !== wd) bad++;
         ch_ack    = noise ? N'($urandom) : '0;
         ch_ack[c] = (k - 1 >= dly);
      end
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      ch_ack    = '0;
      tick();
      if (wbs_ack_o || wbs_err_o || wbs_dat_o !== '0 || ch_req !== '0) bad++;
   endtask

   task automatic test_reset();
      logic [W-1:0] obs;
      rst_n = 1'b0;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
      wbs_adr_i = 32'h4000_0000; wbs_dat_i = 32'h5555_AAAA;
      ch_ack = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         obs = W'({wbs_ack_o, wbs_err_o, ch_req, ch_we, timeout_count, last_err_ch})
               | wbs_dat_o | W'(ch_addr) | ch_wdata;
         if (obs !== '0) begin
            nerr++;
            $display("FAIL reset_outputs cyc%0d: got %h, want 0", i, obs);
         end
      end
      rst_n = 1'b1;
      tick();
      nvec++;
      if (ch_req !== 4'b0010) begin
         nerr++;
         $display("FAIL reset_release_req: got %b, want 0010", ch_req);
      end
      ch_ack[1] = 1'b1;
      tick();
      nvec++;
      if (wbs_ack_o !== 1'b1) begin
         nerr++;
         $display("FAIL reset_first_ack: got %b, want 1", wbs_ack_o);
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; ch_ack = '0;
      tick();
      wbs_adr_i = 32'h8000_0000; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      tick();
      rst_n = 1'b0;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      ch_ack[2] = 1'b1;
      tick();
      nvec++;
      if (ch_req !== '0 || wbs_ack_o !== 1'b0 || wbs_err_o !== 1'b0) begin
         nerr++;
         $display("FAIL reset_midxfer: req=%b ack=%b err=%b, want 0/0/0",
                  ch_req, wbs_ack_o, wbs_err_o);
      end
      rst_n = 1'b1; ch_ack = '0;
      tick();
   endtask

   task automatic test_read_zero_wait();
      rd[2] = 32'h1234_5678;
      wbs_adr_i = 32'h8000_0010; wbs_we_i = 1'b0; wbs_dat_i = '0;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      ch_ack = 4'b0100;
      tick();
      nvec++;
      if (ch_req !== 4'b0100 || wbs_ack_o !== 1'b0) begin
         nerr++;
         $display("FAIL read0_cycle1: req=%b ack=%b, want 0100/0", ch_req, wbs_ack_o);
      end
      tick();
      nvec++;
      if (wbs_ack_o !== 1'b1 || wbs_err_o !== 1'b0 || wbs_dat_o !== 32'h1234_5678) begin
         nerr++;
         $display("FAIL read0_cycle2: ack=%b err=%b dat=%h, want 1/0/12345678",
                  wbs_ack_o, wbs_err_o, wbs_dat_o);
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      tick();
      nvec++;
      if (wbs_ack_o !== 1'b0 || wbs_dat_o !== '0) begin
         nerr++;
         $display("FAIL read0_cycle3: ack=%b dat=%h, want 0/0", wbs_ack_o, wbs_dat_o);
      end
      ch_ack = '0;
   endtask

   task automatic test_write_wait();
      int held;
      held = 0;
      wbs_adr_i = 32'h4000_0003; wbs_we_i = 1'b1; wbs_dat_i = 32'h0000_00A5;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; ch_ack = '0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (ch_req === 4'b0010 && ch_addr === 30'h3 && ch_wdata === 32'hA5
             && ch_we === 1'b1 && !wbs_ack_o) held++;
         if (i == 4) ch_ack[1] = 1'b1;
      end
      nvec++;
      if (held != 4) begin
         nerr++;
         $display("FAIL write_hold: held %0d cycles, want 4", held);
      end
      tick();
      nvec++;
      if (wbs_ack_o !== 1'b1 || wbs_dat_o !== '0 || ch_req !== '0) begin
         nerr++;
         $display("FAIL write_ack: ack=%b dat=%h req=%b, want 1/0/0",
                  wbs_ack_o, wbs_dat_o, ch_req);
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; ch_ack = '0;
      tick();
      nvec++;
      if (wbs_ack_o !== 1'b0 || ch_we !== 1'b1 || ch_wdata !== 32'hA5) begin
         nerr++;
         $display("FAIL write_after: ack=%b we=%b wdata=%h, want 0/1/a5",
                  wbs_ack_o, ch_we, ch_wdata);
      end
   endtask

   task automatic test_timeout();
      bit a, e; logic [W-1:0] d; int lat, nr, bad, fr, rc;
      rd[3] = 32'hCAFE_0003;
      xfer(3, 1'b0, 30'h20, '0, 999, 1'b0, a, e, d, lat, nr, bad, fr, rc);
      exp_tcnt = (exp_tcnt < 255) ? exp_tcnt + 1 : 255;
      exp_last = 3;
      nvec++;
      if (a !== 1'b0 || e !== 1'b1 || d !== ERRV || lat != TO + 1 || nr != TO || bad != 0) begin
         nerr++;
         $display("FAIL timeout_resp: ack=%b err=%b dat=%h lat=%0d nreq=%0d bad=%0d, want 0/1/%h/%0d/%0d/0",
                  a, e, d, lat, nr, bad, ERRV, TO + 1, TO);
      end
      nvec++;
      if (timeout_count !== 8'(exp_tcnt) || last_err_ch !== SB'(exp_last)) begin
         nerr++;
         $display("FAIL timeout_status: cnt=%0d last=%0d, want %0d/%0d",
                  timeout_count, last_err_ch, exp_tcnt, exp_last);
      end
   endtask

   task automatic test_random();
      bit a, e; logic [W-1:0] d; int lat, nr, bad, fr, rc;
      int c, dly; bit we; logic [AW-1:0] lo; logic [W-1:0] wd;
      bit xa; int xlat, xnr; logic [W-1:0] xd;
      for (int t = 0; t < 40; t++) begin
         c   = int'($urandom_range(0, N - 1));
         we  = 1'($urandom);
         lo  = AW'($urandom);
         wd  = $urandom;
         dly = int'($urandom_range(0, TO + 3));
         rd[c] = $urandom;
         xa   = (dly < TO);
         xlat = xa ? dly + 2 : TO + 1;
         xnr  = xa ? dly + 1 : TO;
         xd   = !xa ? ERRV : (we ? '0 : rd[c]);
         if (!xa) begin
            exp_tcnt = (exp_tcnt < 255) ? exp_tcnt + 1 : 255;
            exp_last = c;
         end
         xfer(c, we, lo, wd, dly, 1'b1, a, e, d, lat, nr, bad, fr, rc);
         nvec++;
         if (a !== xa || e !== !xa || d !== xd) begin
            nerr++;
            $display("FAIL rand%0d_resp: ack=%b err=%b dat=%h, want %b/%b/%h",
                     t, a, e, d, xa, !xa, xd);
         end
         nvec++;
         if (lat != xlat || nr != xnr || bad != 0) begin
            nerr++;
            $display("FAIL rand%0d_timing: lat=%0d nreq=%0d bad=%0d, want %0d/%0d/0",
                     t, lat, nr, bad, xlat, xnr);
         end
         nvec++;
         if (timeout_count !== 8'(exp_tcnt) || last_err_ch !== SB'(exp_last)) begin
            nerr++;
            $display("FAIL rand%0d_status: cnt=%0d last=%0d, want %0d/%0d",
                     t, timeout_count, last_err_ch, exp_tcnt, exp_last);
         end
      end
   endtask

   task automatic test_abort_stray();
      wbs_adr_i = 32'h0000_0040; wbs_we_i = 1'b0; wbs_dat_i = '0;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; ch_ack = '0;
      tick();
      ch_ack[1] = 1'b1;
      tick();
      nvec++;
      if (ch_req !== 4'b0001 || wbs_ack_o !== 1'b0) begin
         nerr++;
         $display("FAIL stray_ack: req=%b ack=%b, want 0001/0", ch_req, wbs_ack_o);
      end
      wbs_cyc_i = 1'b0; ch_ack = '0;
      tick();
      nvec++;
      if (ch_req !== '0 || wbs_ack_o !== 1'b0 || wbs_err_o !== 1'b0) begin
         nerr++;
         $display("FAIL abort: req=%b ack=%b err=%b, want 0/0/0", ch_req, wbs_ack_o, wbs_err_o);
      end
      wbs_stb_i = 1'b0;
      ch_ack[0] = 1'b1;
      tick();
      tick();
      nvec++;
      if (ch_req !== '0 || wbs_ack_o !== 1'b0 || wbs_err_o !== 1'b0
          || timeout_count !== 8'(exp_tcnt)) begin
         nerr++;
         $display("FAIL late_ack: req=%b ack=%b err=%b cnt=%0d, want 0/0/0/%0d",
                  ch_req, wbs_ack_o, wbs_err_o, timeout_count, exp_tcnt);
      end
      ch_ack = '0;
   endtask

   task automatic test_back_to_back();
      bit a0, e0, a1, e1; logic [W-1:0] d0, d1;
      int l0, n0, b0, f0, r0, l1, n1, b1, f1, r1;
      logic [W-1:0] v0, v3;
      v0 = $urandom; v3 = $urandom;
      rd[0] = v0; rd[3] = v3;
      xfer(0, 1'b0, 30'h4, '0, 0, 1'b0, a0, e0, d0, l0, n0, b0, f0, r0);
      xfer(3, 1'b0, 30'h8, '0, 0, 1'b0, a1, e1, d1, l1, n1, b1, f1, r1);
      nvec++;
      if (a0 !== 1'b1 || d0 !== v0 || b0 != 0) begin
         nerr++;
         $display("FAIL b2b_first: ack=%b dat=%h bad=%0d, want 1/%h/0", a0, d0, b0, v0);
      end
      nvec++;
      if (a1 !== 1'b1 || d1 !== v3 || b1 != 0) begin
         nerr++;
         $display("FAIL b2b_second: ack=%b dat=%h bad=%0d, want 1/%h/0", a1, d1, b1, v3);
      end
      nvec++;
      if (f1 != r0 + 2) begin
         nerr++;
         $display("FAIL b2b_gap: second req at %0d, want %0d", f1, r0 + 2);
      end
   endtask

   task automatic test_saturate();
      bit a, e; logic [W-1:0] d; int lat, nr, bad, fr, rc;
      for (int i = 0; i < 260; i++) begin
         xfer(1, 1'b0, 30'h0, '0, 999, 1'b0, a, e, d, lat, nr, bad, fr, rc);
         exp_tcnt = (exp_tcnt < 255) ? exp_tcnt + 1 : 255;
         exp_last = 1;
      end
      nvec++;
      if (timeout_count !== 8'(exp_tcnt) || last_err_ch !== SB'(exp_last) || e !== 1'b1) begin
         nerr++;
         $display("FAIL saturate: cnt=%0d last=%0d err=%b, want %0d/%0d/1",
                  timeout_count, last_err_ch, e, exp_tcnt, exp_last);
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) rd[k] = '0;
      test_reset();
      test_read_zero_wait();
      test_write_wait();
      test_timeout();
      test_random();
      test_abort_stray();
      test_back_to_back();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/wb_router.md
Name: wb_router

Overview:
- Registered Wishbone classic-cycle slave that routes each host transfer to one of CHANNELS target ports.
- Targets use a req/ack handshake and may insert wait states.
- A per-transfer timeout terminates hung accesses with an error response; saturating status counters record timeouts.
- Sits between the Caravel Wishbone bus and the programmer, pads, debugger and entropy targets. It replaces the purely combinational single-cycle demux where targets need more than one cycle.

Parameters:
- WB_WIDTH, 32, Wishbone address/data width.
- CHANNELS, 4, number of target channels; power of two, ≥2.
- SEL_BITS, $clog2(CHANNELS), address MSBs used as channel select.
- TIMEOUT, 16, cycles in REQ without ch_ack before error termination; 1..255.
- ERR_DATA, 32'hDEAD_BEEF, value driven on wbs_dat_o on error/timeout.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous reset, active low.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  1=write, 0=read.
- wbs_adr_i  in  WB_WIDTH  address; [WB_WIDTH-1 -: SEL_BITS] selects channel.
- wbs_dat_i  in  WB_WIDTH  write data.
- wbs_ack_o  out  1  normal termination, one-cycle pulse.
- wbs_err_o  out  1  error termination, one-cycle pulse.
- wbs_dat_o  out  WB_WIDTH  registered read data.
- ch_req  out  CHANNELS  one-hot request, held until ack, abort or timeout.
- ch_we  out  1  latched write flag, shared by all channels.
- ch_addr  out  WB_WIDTH-SEL_BITS  latched low address bits, shared.
- ch_wdata  out  WB_WIDTH  latched write data, shared.
- ch_ack  in  CHANNELS  target completion, one bit per channel.
- ch_rdata  in  CHANNELS*WB_WIDTH  flattened read data; channel k at [k*WB_WIDTH +: WB_WIDTH].
- timeout_count  out  8  saturating count of timed-out transfers.
- last_err_ch  out  SEL_BITS  channel of the most recent timeout.

Behaviour:
- Reset (rst_n=0 at posedge) values: state=IDLE; ch_req=0, ch_we=0, ch_addr=0, ch_wdata=0; wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0; timeout_count=0, last_err_ch=0; timer=0. Reset mid-transfer drops ch_req the next cycle and issues no ack/err.
- FSM states: IDLE, REQ, RESP.
- IDLE: if stb&&cyc, latch sel, we, low address and write data; set ch_req[sel]; timer=0; go to REQ.
- REQ, abort: if cyc=0 or stb=0, clear ch_req and go to IDLE. No ack/err. A later ch_ack is ignored.
- REQ, completion: if ch_ack[sel]=1, clear ch_req. If read, capture ch_rdata[sel] into wbs_dat_o; writes leave wbs_dat_o=0. Set wbs_ack_o=1 and go to RESP.
- REQ, timeout: else if timer==TIMEOUT-1, clear ch_req, wbs_dat_o=ERR_DATA, wbs_err_o=1, timeout_count+=1 (saturate at 255), last_err_ch=sel, go to RESP.
- REQ, otherwise: timer+=1.
- If ch_ack and timeout occur in the same cycle, ack wins.
- ch_ack bits of non-selected channels are ignored at all times.
- RESP: ack/err is high for exactly this one cycle. Next cycle: ack=err=0, wbs_dat_o=0, go to IDLE.
- No new transfer is accepted in RESP. The cycle after RESP (IDLE) may accept the next strobe.
- Latency: strobe sampled in cycle 0, ch_req visible in cycle 1. With a same-cycle ch_ack in cycle 1, wbs_ack_o is high in cycle 2. Minimum is 2 cycles per transfer plus the IDLE turnaround.
- ch_we, ch_addr and ch_wdata stay stable while ch_req is high, and hold their last values otherwise.
- At most one ch_req bit is ever high.
- wbs_ack_o and wbs_err_o are never high together.

Decomposition:
- Shared package/defines: FSM state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2), ERR_DATA default, WB_WIDTH, and the channel index map (PROG=0, PADS=1, DEBUG=2, ENTROPY=3).
- One sub-module: wb_router_timer, a loadable TIMEOUT down-counter with clear and expiry strobe.
- The rest stays in wb_router.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with stb=cyc=1 → all outputs 0, no ch_req; release → ch_req[sel] rises the next cycle.
- Read ch2, zero wait: adr=32'h8000_0010, we=0, ch_ack[2] tied high, ch_rdata[2]=32'h1234_5678 → ch_req=4'b0100 in cycle 1; wbs_ack_o=1 and wbs_dat_o=32'h1234_5678 in cycle 2 only.
- Write ch1, 3 wait states: adr=32'h4000_0003, dat=32'h0000_00A5, ch_ack[1] asserted 3 cycles after req → ch_addr=30'h3, ch_wdata=32'hA5, ch_we=1 held for 4 cycles; single ack pulse; wbs_dat_o=0.
- Timeout: read ch3 with ch_ack held 0 and TIMEOUT=16 → ch_req high for 16 cycles; then wbs_err_o=1, wbs_dat_o=32'hDEAD_BEEF, timeout_count=1, last_err_ch=3. 260 repeats → timeout_count=255.
- Abort and stray ack: drop cyc in cycle 2 of a ch0 request → ch_req=0 next cycle, no ack/err; ch_ack[1] pulsed during a ch0 request → ignored.
- Back-to-back: two reads (ch0, then ch3) with stb re-raised in the cycle after ack → two ack pulses, correct per-channel data, each second ch_req delayed by exactly one IDLE cycle.
